ctrl_store_loader: RTL and testbench

CTRL_STORE_LOADER -- requirements
Module: ctrl_store_loader

---
 rtl/ctrl_pkg.sv | 19 +
 rtl/cs_word_pack.sv | 45 ++++
 rtl/ctrl_store_loader.sv | 144 ++++++++++++++
 tb/tb_ctrl_store_loader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-store loader: default widths,
// the frame header byte and the loader state encoding.
package ctrl_pkg;

    localparam int          CS_W_I_DEF = 9;
    localparam int          CS_W_C_DEF = 26;
    localparam logic [7:0]  CS_HDR     = 8'hA5;

    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_ADDR_HI = 3'd1,
        LD_ADDR_LO = 3'd2,
        LD_COUNT   = 3'd3,
        LD_DATA    = 3'd4,
        LD_WRITE   = 3'd5,
        LD_CHECK   = 3'd6
    } ld_state_e;

endpackage

// File: rtl/cs_word_pack.sv
// Byte-to-word assembler: collects four little-endian bytes into one
// microinstruction. The word register holds its value until the next byte
// arrives, so the assembled word stays stable while the store write is pending.
module cs_word_pack #(
    parameter int W_C = 26
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           clr,
    input  logic           byte_vld,
    input  logic [7:0]     byte_in,
    output logic [W_C-1:0] word,
    output logic           last
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    // Place the incoming byte at the current lane and advance the lane index.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clr) begin
            idx_d = 2'd0;
        end else if (byte_vld) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_in;
            idx_d = idx_q + 2'd1;
        end
    end

    // Lane index and word storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word = word_q[W_C-1:0];
    assign last = byte_vld && !clr && (idx_q == 2'd3);

endmodule

// File: rtl/ctrl_store_loader.sv
// Control-store loader: parses framed byte stream
// (A5, ADDR_HI, ADDR_LO, COUNT, COUNT x 4 data bytes, CHK) and issues one
// store write per assembled word, then reports the XOR checksum result.
module ctrl_store_loader
    import ctrl_pkg::*;
#(
    parameter int W_I = CS_W_I_DEF,
    parameter int W_C = CS_W_C_DEF
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [7:0]     in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           wr_en,
    output logic [W_I-1:0] wr_addr,
    output logic [W_C-1:0] wr_data,
    input  logic           wr_ready,
    output logic           busy,
    output logic           done,
    output logic           err
);

    ld_state_e      state_q, state_d;
    logic [W_I-1:0] addr_q, addr_d;
    logic [8:0]     cnt_q, cnt_d;      // remaining words; 256 needs the 9th bit
    logic [7:0]     chk_q, chk_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           acc;
    logic           pack_clr;
    logic           pack_vld;
    logic           pack_last;
    logic [W_C-1:0] pack_word;

    assign acc      = in_valid && in_ready;
    assign pack_clr = (state_q == LD_IDLE);
    assign pack_vld = acc && (state_q == LD_DATA);

    cs_word_pack #(
        .W_C (W_C)
    ) u_pack (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (pack_clr),
        .byte_vld (pack_vld),
        .byte_in  (in_data),
        .word     (pack_word),
        .last     (pack_last)
    );

    // Next-state, address/count/checksum bookkeeping and result pulses.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            LD_IDLE: begin
                if (acc && in_data == CS_HDR) begin
                    state_d = LD_ADDR_HI;
                    chk_d   = 8'd0;
                end
            end
            LD_ADDR_HI: begin
                if (acc) begin
                    addr_d[W_I-1:8] = in_data[W_I-9:0];
                    chk_d           = chk_q ^ in_data;
                    state_d         = LD_ADDR_LO;
                end
            end
            LD_ADDR_LO: begin
                if (acc) begin
                    addr_d[7:0] = in_data;
                    chk_d       = chk_q ^ in_data;
                    state_d     = LD_COUNT;
                end
            end
            LD_COUNT: begin
                if (acc) begin
                    cnt_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    chk_d   = chk_q ^ in_data;
                    state_d = LD_DATA;
                end
            end
            LD_DATA: begin
                if (acc) begin
                    chk_d = chk_q ^ in_data;
                    if (pack_last) begin
                        state_d = LD_WRITE;
                    end
                end
            end
            LD_WRITE: begin
                if (wr_ready) begin
                    addr_d  = addr_q + {{(W_I-1){1'b0}}, 1'b1};
                    cnt_d   = cnt_q - 9'd1;
                    state_d = (cnt_q == 9'd1) ? LD_CHECK : LD_DATA;
                end
            end
            LD_CHECK: begin
                if (acc) begin
                    done_d  = (in_data == chk_q);
                    err_d   = (in_data != chk_q);
                    state_d = LD_IDLE;
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LD_IDLE;
            addr_q  <= '0;
            cnt_q   <= 9'd0;
            chk_q   <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready = (state_q != LD_WRITE);
    assign busy     = (state_q != LD_IDLE);
    assign wr_en    = (state_q == LD_WRITE);
    assign wr_addr  = addr_q;
    assign wr_data  = pack_word;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ctrl_store_loader.sv
// Self-checking bench for ctrl_store_loader: directed frames plus randomized
// frames, compared against a frame-level reference model of expected writes.
module tb_ctrl_store_loader;

    localparam int W_I = 9;
    localparam int W_C = 26;

    logic           clk = 1'b0;
    logic           rstn;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_ready;
    logic           wr_en;
    logic [W_I-1:0] wr_addr;
    logic [W_C-1:0] wr_data;
    logic           wr_ready;
    logic           busy;
    logic           done;
    logic           err;

    ctrl_store_loader #(.W_I(W_I), .W_C(W_C)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W_I-1:0] a;
        logic [W_C-1:0] d;
    } wr_t;

    int          n_chk = 0;
    int          n_err = 0;
    wr_t         exp_q[$];
    wr_t         log_q[$];
    logic [7:0]  frm[$];
    logic [31:0] wq[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          run_len = 0;
    int          last_run = 0;
    int          ready_mode = 0;
    int          stall = 0;
    logic        prev_stall = 1'b0;
    logic [W_I-1:0] prev_addr;
    logic [W_C-1:0] prev_data;
    wr_t         mon_e;
    int          snap_done, snap_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: build the byte frame and the writes it must cause.
    task automatic make_frame(input int addr, input int n, input bit bad, input bit junk);
        logic [7:0]  c;
        logic [7:0]  hi;
        logic [31:0] w;
        wr_t         e;
        hi = 8'((addr >> 8) & 1);
        if (junk) hi = hi | (8'($urandom) & 8'hFE);
        frm.delete();
        frm.push_back(8'hA5);
        frm.push_back(hi);
        frm.push_back(8'(addr));
        frm.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = (i < wq.size()) ? wq[i] : $urandom;
            for (int b = 0; b < 4; b++) frm.push_back(8'(w >> (8 * b)));
            e.a = W_I'((addr + i) % 512);
            e.d = W_C'(w);
            exp_q.push_back(e);
        end
        c = 8'd0;
        for (int j = 1; j < frm.size(); j++) c = c ^ frm[j];
        if (bad) c = ~c;
        frm.push_back(c);
    endtask

    // Offer one byte (with random idle gaps) until the loader accepts it.
    task automatic send_byte(input logic [7:0] b);
        logic accepted;
        int   guard;
        accepted = 1'b0;
        guard    = 0;
        while (!accepted) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = in_valid ? b : 8'($urandom);
            accepted = in_valid && in_ready;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            guard++;
            if (guard > 400) begin
                check("send_timeout", {63'd0, in_ready}, 64'd1);
                return;
            end
        end
    endtask

    task automatic send_frame_bytes(input int upto);
        for (int i = 0; i < upto && i < frm.size(); i++) send_byte(frm[i]);
    endtask

    task automatic finish_frame(input string tag, input int exp_done, input int exp_err);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done"}, 64'(done_cnt - snap_done), 64'(exp_done));
        check({tag, "_err"}, 64'(err_cnt - snap_err), 64'(exp_err));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic start_frame();
        snap_done = done_cnt;
        snap_err  = err_cnt;
        log_q.delete();
        wq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    // Store-side acceptance pattern.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: wr_ready = 1'b1;
                1: wr_ready = ($urandom_range(0, 1) == 1);
                default: begin
                    if (wr_en && stall < 3) begin
                        wr_ready = 1'b0;
                        stall++;
                    end else begin
                        wr_ready = 1'b1;
                        if (!wr_en) stall = 0;
                    end
                end
            endcase
        end
    end

    // Output monitor: write ordering, hold stability, pulse exclusivity.
    always @(negedge clk) begin
        if (rstn) begin
            check("done_err_excl", {63'd0, done & err}, 64'd0);
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (wr_en) begin
                check("in_ready_in_write", {63'd0, in_ready}, 64'd0);
                if (prev_stall) begin
                    check("addr_hold", 64'(wr_addr), 64'(prev_addr));
                    check("data_hold", 64'(wr_data), 64'(prev_data));
                end
                run_len++;
                if (wr_ready) begin
                    if (exp_q.size() == 0) begin
                        check("wr_unexpected", {63'd0, wr_en & wr_ready}, 64'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wr_addr", 64'(wr_addr), 64'(mon_e.a));
                        check("wr_data", 64'(wr_data), 64'(mon_e.d));
                    end
                    mon_e.a = wr_addr;
                    mon_e.d = wr_data;
                    log_q.push_back(mon_e);
                end
            end else if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
            prev_stall = wr_en && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end else begin
            prev_stall = 1'b0;
            run_len    = 0;
        end
    end

    initial begin
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        #2;
        check_reset_outputs("rst");
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

        // Single word, store always ready.
        start_frame();
        ready_mode = 0;
        wq.push_back(32'h02345678);
        make_frame(12'h010, 1, 1'b0, 1'b0);
        send_frame_bytes(frm.size());
        finish_frame("single", 1, 0);
        check("single_nwr", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) begin
            check("single_addr", 64'(log_q[0].a), 64'h010);
            check("single_data", 64'(log_q[0].d), 64'h2345678);
        end
        check("single_run", 64'(last_run), 64'd1);

        // Same frame with the store stalling three cycles.
        start_frame();
        ready_mode = 2;
        wq.push_back(32'h02345678);
        make_frame(12'h010, 1, 1'b0, 1'b0);
        send_frame_bytes(frm.size());
        finish_frame("bp", 1, 0);
        check("bp_run", 64'(last_run), 64'd4);
        check("bp_nwr", 64'(log_q.size()), 64'd1);

        // Address wrap-around.
        start_frame();
        ready_mode = 0;
        make_frame(12'h1FF, 2, 1'b0, 1'b0);
        send_frame_bytes(frm.size());
        finish_frame("wrap", 1, 0);
        check("wrap_nwr", 64'(log_q.size()), 64'd2);
        if (log_q.size() > 1) begin
            check("wrap_addr0", 64'(log_q[0].a), 64'h1FF);
            check("wrap_addr1", 64'(log_q[1].a), 64'h000);
        end

        // Bad checksum: write still lands, err reported.
        start_frame();
        make_frame(12'h020, 1, 1'b1, 1'b0);
        send_frame_bytes(frm.size());
        finish_frame("badchk", 0, 1);
        check("badchk_nwr", 64'(log_q.size()), 64'd1);

        // Garbage in IDLE.
        start_frame();
        send_byte(8'h00);
        check("garbage0_busy", {63'd0, busy}, 64'd0);
        send_byte(8'hFF);
        check("garbage1_busy", {63'd0, busy}, 64'd0);
        send_byte(8'h13);
        check("garbage2_busy", {63'd0, busy}, 64'd0);

        // Reset during DATA, then a clean frame.
        start_frame();
        make_frame(12'h055, 2, 1'b0, 1'b0);
        send_frame_bytes(6);
        check("mid_busy", {63'd0, busy}, 64'd1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("mid_in_ready", {63'd0, in_ready}, 64'd1);
        wq.delete();
        make_frame(12'h0AA, 2, 1'b0, 1'b0);
        send_frame_bytes(frm.size());
        finish_frame("after_rst", 1, 0);
        check("after_rst_nwr", 64'(log_q.size()), 64'd2);

        // Randomized frames with random store backpressure.
        ready_mode = 1;
        for (int f = 0; f < 14; f++) begin
            bit bad;
            int n;
            start_frame();
            bad = ($urandom_range(0, 3) == 0);
            n   = $urandom_range(1, 6);
            if ($urandom_range(0, 2) == 0) wq.push_back(32'hA5A5A5A5);
            make_frame($urandom_range(0, 511), n, bad, 1'b1);
            send_frame_bytes(frm.size());
            finish_frame("rand", bad ? 0 : 1, bad ? 1 : 0);
            check("rand_nwr", 64'(log_q.size()), 64'(n));
        end

        // COUNT of zero means 256 words.
        start_frame();
        ready_mode = 0;
        make_frame($urandom_range(0, 511), 256, 1'b0, 1'b1);
        send_frame_bytes(frm.size());
        finish_frame("c256", 1, 0);
        check("c256_nwr", 64'(log_q.size()), 64'd256);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
